// File: rtl/alien_hit_detector.sv
// alien_hit_detector
// Tests each updated player-bullet position against the alive-alien grid.
// On a hit it pulses collided, clears the alien, bumps a saturating score
// and requests an erase of the alien's sprite from the draw arbiter.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   bulletValid           pulse: bulletX/bulletY just updated
//   bulletX, bulletY      bullet pixel position
//   gridX, gridY          grid origin (top-left of alien row0/col0)
//   newWave               pulse: reload all aliens alive (IDLE only)
//   eraseAck              draw arbiter accepted the erase request
//   collided              one-cycle hit pulse
//   eraseReq              erase request, held until eraseAck
//   eraseX, eraseY        top-left of the alien to erase
//   aliveMask             bit r*COLS+c set while alien (r,c) is alive
//   score                 hits this game, saturating at 255
//   allDead               aliveMask == 0 (combinational)
module alien_hit_detector #(
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 8,
  parameter int unsigned X_SPACING = 16,
  parameter int unsigned Y_SPACING = 16,
  parameter int unsigned ALIEN_W   = 10,
  parameter int unsigned ALIEN_H   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bulletValid,
  input  logic [7:0]           bulletX,
  input  logic [6:0]           bulletY,
  input  logic [7:0]           gridX,
  input  logic [6:0]           gridY,
  input  logic                 newWave,
  input  logic                 eraseAck,
  output logic                 collided,
  output logic                 eraseReq,
  output logic [7:0]           eraseX,
  output logic [6:0]           eraseY,
  output logic [ROWS*COLS-1:0] aliveMask,
  output logic [7:0]           score,
  output logic                 allDead
);

  localparam int unsigned N       = ROWS * COLS;
  localparam int unsigned XS_LOG2 = $clog2(X_SPACING);
  localparam int unsigned YS_LOG2 = $clog2(Y_SPACING);
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, HIT, ERASE} state_t;

  state_t state, next_state;

  // Latched bullet/grid snapshot and the cell found in CHECK
  logic [7:0]       bx_q, gx_q;
  logic [6:0]       by_q, gy_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [IDX_W-1:0] idx_q;

  // Hit-test datapath on the latched snapshot
  logic [8:0]       dx_c;
  logic [7:0]       dy_c;
  logic [7:0]       col_full, offx;
  logic [6:0]       row_full, offy;
  logic             in_cell_c;
  logic [IDX_W-1:0] idx_c;
  logic             hit_c;

  // Decoded controls
  logic load_bullet_c, reload_mask_c, latch_cell_c, commit_hit_c;
  logic collided_d, erase_req_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!newWave && bulletValid) next_state = CHECK;
      CHECK:   next_state = hit_c ? HIT : IDLE;
      HIT:     next_state = ERASE;
      ERASE:   if (eraseAck) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    load_bullet_c = 1'b0;
    reload_mask_c = 1'b0;
    latch_cell_c  = 1'b0;
    commit_hit_c  = 1'b0;
    collided_d    = (next_state == HIT);
    erase_req_d   = (next_state == ERASE);
    unique case (state)
      IDLE: begin
        reload_mask_c = newWave;
        load_bullet_c = !newWave && bulletValid;
      end
      CHECK:   latch_cell_c = 1'b1;
      HIT:     commit_hit_c = 1'b1;
      default: ;
    endcase
  end

  // Geometry: offsets are non-negative only when the sign bit is clear;
  // pitches are powers of two so col/row/offset are shifts and masks.
  always_comb begin
    dx_c      = {1'b0, bx_q} - {1'b0, gx_q};
    dy_c      = {1'b0, by_q} - {1'b0, gy_q};
    col_full  = dx_c[7:0] >> XS_LOG2;
    row_full  = dy_c[6:0] >> YS_LOG2;
    offx      = dx_c[7:0] & 8'(X_SPACING - 1);
    offy      = dy_c[6:0] & 7'(Y_SPACING - 1);
    in_cell_c = !dx_c[8] && !dy_c[7] &&
                (col_full < 8'(COLS)) && (row_full < 7'(ROWS)) &&
                (offx < 8'(ALIEN_W)) && (offy < 7'(ALIEN_H));
    // Index forced to 0 off-grid so the mask is never read out of range
    idx_c     = in_cell_c ? IDX_W'(32'(row_full) * COLS + 32'(col_full)) : '0;
    hit_c     = in_cell_c && aliveMask[idx_c];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q      <= '0;
      by_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      aliveMask <= '1;
      score     <= '0;
      collided  <= 1'b0;
      eraseReq  <= 1'b0;
      eraseX    <= '0;
      eraseY    <= '0;
    end else begin
      collided <= collided_d;
      eraseReq <= erase_req_d;
      if (reload_mask_c) aliveMask <= '1;
      if (load_bullet_c) begin
        bx_q <= bulletX;
        by_q <= bulletY;
        gx_q <= gridX;
        gy_q <= gridY;
      end
      if (latch_cell_c) begin
        col_q <= CW'(col_full);
        row_q <= RW'(row_full);
        idx_q <= idx_c;
      end
      if (commit_hit_c) begin
        aliveMask[idx_q] <= 1'b0;
        if (score != 8'hFF) score <= score + 8'd1;
        eraseX <= gx_q + 8'(32'(col_q) * X_SPACING);
        eraseY <= gy_q + 7'(32'(row_q) * Y_SPACING);
      end
    end
  end

  assign allDead = (aliveMask == '0);

endmodule

// File: tb/tb_alien_hit_detector.sv
module tb_alien_hit_detector;

  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int XSP  = 16;
  localparam int YSP  = 16;
  localparam int AW   = 10;
  localparam int AH   = 8;
  localparam int NC   = ROWS * COLS;
  localparam longint NEVER = longint'(1) << 60;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 bulletValid = 1'b0;
  logic [7:0]           bulletX = '0;
  logic [6:0]           bulletY = '0;
  logic [7:0]           gridX = '0;
  logic [6:0]           gridY = '0;
  logic                 newWave = 1'b0;
  logic                 eraseAck = 1'b0;
  logic                 collided;
  logic                 eraseReq;
  logic [7:0]           eraseX;
  logic [6:0]           eraseY;
  logic [NC-1:0]        aliveMask;
  logic [7:0]           score;
  logic                 allDead;

  int checks = 0;
  int errors = 0;
  bit ack_en = 1'b1;

  alien_hit_detector dut (
    .clk(clk), .reset(reset), .bulletValid(bulletValid),
    .bulletX(bulletX), .bulletY(bulletY), .gridX(gridX), .gridY(gridY),
    .newWave(newWave), .eraseAck(eraseAck), .collided(collided),
    .eraseReq(eraseReq), .eraseX(eraseX), .eraseY(eraseY),
    .aliveMask(aliveMask), .score(score), .allDead(allDead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Cycle c is the c-th clock period; a bullet accepted in cycle t is
  // reported in cycle t+2 and its effects become visible from t+3.
  longint       cyc = 0;
  bit           m_valid = 1'b0;
  bit [NC-1:0]  m_alive;
  int           m_score;
  bit           m_req;
  int           m_ex, m_ey;
  longint       m_hit_cyc = -1;
  longint       m_free_at = 0;
  int           p_idx, p_ex, p_ey;

  task automatic model_eval(input int bx, input int by, input int gx, input int gy,
                            output bit hit, output int idx, output int ex, output int ey);
    int dx, dy, col, row;
    dx = bx - gx;
    dy = by - gy;
    hit = 1'b0; idx = 0; ex = 0; ey = 0;
    if (dx >= 0 && dy >= 0) begin
      col = dx / XSP;
      row = dy / YSP;
      if (col < COLS && row < ROWS && (dx % XSP) < AW && (dy % YSP) < AH) begin
        idx = row * COLS + col;
        hit = m_alive[idx];
        ex  = (gx + col * XSP) % 256;
        ey  = (gy + row * YSP) % 128;
      end
    end
  endtask

  always @(posedge clk) begin
    longint t;
    bit h;
    int i, x, y;
    t = cyc;
    if (reset) begin
      m_valid   = 1'b1;
      m_alive   = '1;
      m_score   = 0;
      m_req     = 1'b0;
      m_ex      = 0;
      m_ey      = 0;
      m_hit_cyc = -1;
      m_free_at = t + 1;
    end else if (t == m_hit_cyc) begin
      m_alive[p_idx] = 1'b0;
      if (m_score < 255) m_score++;
      m_ex  = p_ex;
      m_ey  = p_ey;
      m_req = 1'b1;
    end else if (m_req) begin
      if (eraseAck) begin
        m_req     = 1'b0;
        m_free_at = t + 1;
      end
    end else if (t >= m_free_at) begin
      if (newWave) m_alive = '1;
      else if (bulletValid) begin
        model_eval(int'(bulletX), int'(bulletY), int'(gridX), int'(gridY), h, i, x, y);
        if (h) begin
          m_hit_cyc = t + 2;
          m_free_at = NEVER;
          p_idx = i; p_ex = x; p_ey = y;
        end else begin
          m_free_at = t + 2;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("collided",  32'(collided),  32'(cyc == m_hit_cyc));
      chk("eraseReq",  32'(eraseReq),  32'(m_req));
      chk("eraseX",    32'(eraseX),    32'(m_ex));
      chk("eraseY",    32'(eraseY),    32'(m_ey));
      chk("aliveMask", 32'(aliveMask), 32'(m_alive));
      chk("score",     32'(score),     32'(m_score));
      chk("allDead",   32'(allDead),   32'(m_alive == '0));
    end
  end

  // Draw arbiter: random acknowledge latency
  initial forever begin
    @(posedge clk);
    #1;
    eraseAck = ack_en && ($urandom_range(0, 2) == 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (cyc >= m_free_at) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: detector still busy at cycle %0d", cyc);
    end
  endtask

  task automatic shot(input int bx, input int by);
    wait_idle();
    bulletX = 8'(bx);
    bulletY = 7'(by);
    bulletValid = 1'b1;
    step();
    bulletValid = 1'b0;
    wait_idle();
  endtask

  task automatic wave();
    wait_idle();
    newWave = 1'b1;
    step();
    newWave = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic hit_cell(input int k);
    int r, c;
    r = k / COLS;
    c = k % COLS;
    shot(20 + c * XSP + $urandom_range(0, AW - 1), 10 + r * YSP + $urandom_range(0, AH - 1));
  endtask

  initial begin
    int k;
    bit seen;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_mask",  32'(aliveMask), 32'h00FF_FFFF);
    chk("reset_score", 32'(score),     32'd0);

    // Directed hit: dx=17, dy=18 -> cell 9, erase at (36,26)
    gridX = 8'd20;
    gridY = 7'd10;
    shot(37, 28);
    chk("hit1_mask",   32'(aliveMask), 32'h00FF_FDFF);
    chk("hit1_score",  32'(score),     32'd1);
    chk("hit1_eraseX", 32'(eraseX),    32'd36);
    chk("hit1_eraseY", 32'(eraseY),    32'd26);

    // Misses: gap column, left of grid, beyond last column, dead cell
    shot(50, 10);
    shot(5, 50);
    shot(148, 10);
    shot(37, 28);
    chk("miss_mask",  32'(aliveMask), 32'h00FF_FDFF);
    chk("miss_score", 32'(score),     32'd1);

    // Boundaries: offX 9 hits, offX 10 misses; offY 7 hits, offY 8 misses
    shot(20 + 2 * XSP + AW, 10);
    shot(20 + 2 * XSP + AW - 1, 10);
    shot(20 + 3 * XSP, 10 + AH);
    shot(20 + 3 * XSP, 10 + AH - 1);
    chk("bound_mask",  32'(aliveMask), 32'h00FF_FDF3);
    chk("bound_score", 32'(score),     32'd3);

    // bulletValid held through CHECK/HIT/ERASE: only the first counts
    ack_en = 1'b0;
    @(posedge clk); #1;
    wait_idle();
    bulletX = 8'(20 + 4 * XSP); bulletY = 7'd10; bulletValid = 1'b1;
    step();
    bulletX = 8'(20 + 5 * XSP);
    repeat (5) step();
    bulletValid = 1'b0;
    chk("busy_score", 32'(score), 32'd4);
    ack_en = 1'b1;
    wait_idle();
    chk("busy_mask", 32'(aliveMask), 32'h00FF_FDE3);

    // newWave wins over a simultaneous bullet
    wait_idle();
    bulletX = 8'd37; bulletY = 7'd28; bulletValid = 1'b1; newWave = 1'b1;
    step();
    bulletValid = 1'b0; newWave = 1'b0;
    repeat (3) step();
    chk("wave_mask",  32'(aliveMask), 32'h00FF_FFFF);
    chk("wave_score", 32'(score),     32'd4);

    // Clear the whole grid
    do_reset();
    for (int i = 0; i < NC; i++) hit_cell(i);
    chk("clear_alldead", 32'(allDead), 32'd1);
    chk("clear_score",   32'(score),   32'd24);

    // Drive the score to saturation across waves
    for (k = NC; k < 256; k++) begin
      if ((k % NC) == 0) wave();
      hit_cell(k % NC);
      if (k == 254) chk("sat_score255", 32'(score), 32'd255);
    end
    chk("sat_hold", 32'(score), 32'd255);

    // Randomised traffic with moving grid, waves and occasional resets
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        gridX = 8'($urandom_range(0, 124));
        gridY = 7'($urandom_range(0, 72));
      end
      bulletX     = 8'(int'(gridX) + $urandom_range(0, 140) - 8);
      bulletY     = 7'(int'(gridY) + $urandom_range(0, 54) - 6);
      bulletValid = ($urandom_range(0, 1) == 0);
      newWave     = ($urandom_range(0, 30) == 0);
      reset       = ($urandom_range(0, 400) == 0);
      step();
    end
    bulletValid = 1'b0;
    newWave = 1'b0;
    reset = 1'b0;

    // Reset while an erase is pending and unacknowledged
    do_reset();
    ack_en = 1'b0;
    @(posedge clk); #1;
    gridX = 8'd20; gridY = 7'd10;
    bulletX = 8'd37; bulletY = 7'd28; bulletValid = 1'b1;
    step();
    bulletValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eraseReq) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("erase_seen", 32'(seen), 32'd1);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("rst_eraseReq", 32'(eraseReq),  32'd0);
    chk("rst_mask",     32'(aliveMask), 32'h00FF_FFFF);
    chk("rst_score",    32'(score),     32'd0);
    reset = 1'b0;
    ack_en = 1'b1;
    shot(37, 28);
    chk("post_rst_score", 32'(score), 32'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alien_hit_detector.md
Name: alien_hit_detector

Overview:
- Consumer end of the player-bullet interface. Takes each updated bullet position from the shot logic, tests it against the alive-alien grid, and returns a one-cycle collided pulse. That pulse drives the shot FSM's collidedWithAlien input.
- On a hit it clears the alien, bumps the score, and issues an erase request (alien top-left) to the VGA draw arbiter.
- Sits between the shot block, alien-movement block (grid origin) and draw arbiter.

Parameters:
- ROWS, 3, alien rows
- COLS, 8, alien columns
- X_SPACING, 16, horizontal pitch in pixels (power of 2)
- Y_SPACING, 16, vertical pitch in pixels (power of 2)
- ALIEN_W, 10, alien sprite width, must be <= X_SPACING
- ALIEN_H, 8, alien sprite height, must be <= Y_SPACING

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bulletValid  in  1  pulse: bullet position just updated
- bulletX  in  8  bullet x pixel
- bulletY  in  7  bullet y pixel
- gridX  in  8  x of grid origin (alien row0/col0 top-left)
- gridY  in  7  y of grid origin
- newWave  in  1  pulse: reload all aliens alive
- eraseAck  in  1  draw arbiter accepted erase
- collided  out  1  one-cycle hit pulse
- eraseReq  out  1  erase request, held until acked
- eraseX  out  8  x of alien to erase
- eraseY  out  7  y of alien to erase
- aliveMask  out  ROWS*COLS  bit r*COLS+c = alien (r,c) alive
- score  out  8  hits this game, saturating
- allDead  out  1  aliveMask == 0 (combinational)

Behaviour:
- Reset: state IDLE; aliveMask all ones; score 0; collided 0; eraseReq 0; eraseX/eraseY 0. Reset in any state, including ERASE, drops eraseReq the next cycle and discards any latched bullet.
- FSM states: IDLE, CHECK, HIT, ERASE.
- IDLE: newWave=1 sets aliveMask all ones; score is unchanged. Otherwise bulletValid=1 latches bulletX/Y and gridX/Y, then -> CHECK. If newWave and bulletValid are high together, newWave wins and the bullet is dropped.
- bulletValid is ignored outside IDLE; no queueing. newWave is ignored outside IDLE.
- CHECK (one cycle):
  - dx = bx - gx and dy = by - gy, as signed 9-/8-bit values.
  - Miss if dx<0 or dy<0.
  - col = dx >> log2(X_SPACING); row = dy >> log2(Y_SPACING).
  - offX = dx mod X_SPACING; offY = dy mod Y_SPACING.
  - Hit iff col<COLS, row<ROWS, offX<ALIEN_W, offY<ALIEN_H, and aliveMask[row*COLS+col]=1.
  - Hit -> HIT with row/col latched; miss -> IDLE with no output activity.
- HIT (one cycle):
  - collided=1.
  - Clear aliveMask bit.
  - score+1, saturating at 255.
  - eraseX = gx + col*X_SPACING (mod 256); eraseY = gy + row*Y_SPACING (mod 128), using latched gx/gy.
  - Go to ERASE.
- ERASE: eraseReq=1, with eraseX/eraseY stable. On eraseAck=1, eraseReq drops next cycle -> IDLE. eraseAck outside ERASE is ignored.
- Latency: bulletValid in cycle N -> collided in cycle N+2, eraseReq from N+3.
- A bullet on an already-dead alien's cell is a miss.
- Boundary cases: dx exactly ALIEN_W-1 is a hit; ALIEN_W is a miss; the same rule applies to dy/ALIEN_H.
- allDead rises the cycle after the last bit clears.

Test Plan:
- After reset, gridX=20, gridY=10, bulletValid with bullet (37,28) -> dx=17, dy=18, index 9. collided pulse 2 cycles later, aliveMask bit 9=0, score=1. eraseReq with eraseX=36, eraseY=26, held until eraseAck, then IDLE.
- Same grid:
  - bullet (50,10): offX=14 -> miss.
  - bullet (5,50): dx<0 -> miss.
  - bullet (148,10): col 8 -> miss.
  - In all three: no collided, mask and score unchanged.
- Repeat bullet (37,28) after the first hit -> miss, score stays 1.
- bulletValid asserted every cycle during CHECK/HIT/ERASE -> only the first is processed. newWave and bulletValid together in IDLE -> mask all ones, no collided.
- Hit all 24 cells in turn, acking each erase -> allDead=1, score=24. Preload score to 255 via 255 hits (newWave between waves) -> stays 255 on the next hit.
- Assert reset while in ERASE with eraseAck held low -> eraseReq=0 next cycle, mask all ones, score 0, IDLE.
